id_ex_stage: RTL
================

# id_ex_stage

Parametrised decode-to-execute stage for the RV32 pipeline: register file with write-through bypass, ID/EX pipeline register with bubble insertion, and an integrated load-use hazard detector driving fetch/decode stalls. Sits between the IF/ID register and the execute stage. It takes the already-decoded control bundle and immediate from the control unit and immediate generator, and presents registered operands, control and register addresses to execute and the forwarding unit. Two saturating performance counters record stall and flush cycles.

## Interface
- XLEN, 32, datapath width
- NREGS, 32, architectural registers (power of two, 2..32); AW = $clog2(NREGS) derived
- CTRL_W, 12, width of decoded control bundle
- MEMREAD_BIT, 1, index of MemRead inside control bundle
- BYPASS, 1, 1 = write-through from W port to D reads
- CNT_W, 16, performance counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- RegWriteW  in  1  writeback enable
- WriteAddressW  in  5  writeback destination
- writeDataW  in  XLEN  writeback data
- validD  in  1  instrD holds a real instruction
- instrD  in  32  instruction in decode
- PCD  in  XLEN  PC of instrD
- ctrlD  in  CTRL_W  decoded control bundle
- immD  in  XLEN  generated immediate
- FlushE  in  1  squash instruction entering execute (taken branch/jump)
- PCE, ReadOut1E, ReadOut2E, ImmE  out  XLEN  registered operands
- ctrlE  out  CTRL_W  registered control, zero for bubbles
- Rs1E, Rs2E, RdE  out  5  registered instrD[19:15], [24:20], [11:7]
- validE  out  1  execute slot holds a real instruction
- StallF, StallD  out  1  hold PC and IF/ID register
- stall_cycles, flush_cycles  out  CNT_W  saturating event counters

## Operation
- Register file: NREGS x XLEN. Write at rising edge when RegWriteW, WriteAddressW != 0 and WriteAddressW < NREGS; otherwise the write is ignored.
- Reads: combinational on instrD[19:15], [24:20]. Index 0 or index >= NREGS reads 0.
- Bypass (BYPASS=1): if RegWriteW and WriteAddressW equals a nonzero, in-range read index, that read returns writeDataW in the same cycle. BYPASS=0 returns the stored value.
- loadUse = validE & ctrlE[MEMREAD_BIT] & (RdE != 0) & validD & (RdE == instrD[19:15] | RdE == instrD[24:20]). Both fields are compared regardless of format (conservative).
- StallF = StallD = loadUse & ~FlushE (combinational).
- ID/EX update, priority order:
  - FlushE: validE <= 0, ctrlE <= 0; data and address fields load normally.
  - loadUse: bubble, validE <= 0, ctrlE <= 0; data fields load normally.
  - Otherwise: all fields load; validE <= validD; ctrlE <= validD ? ctrlD : 0.
- stall_cycles increments on each cycle with StallD = 1. flush_cycles increments on each cycle with FlushE = 1. Both saturate at all-ones; no wrap.

## Timing
- Register-file read and bypass: 0 cycles. D-to-E latency: 1 cycle.
- Load-use stall lasts exactly 1 cycle. The bubble clears the condition, so the dependent instruction enters E on the next edge, and the forwarding unit supplies the result from M/W.
- FlushE together with loadUse: flush wins, StallD = 0, flush_cycles increments, stall_cycles does not.
- Write and read of the same register in the same cycle: the new value with BYPASS=1, the old value with BYPASS=0. The stored value updates at the edge in both cases.
- Reset low at any time: all registers, all outputs (PCE..RdE, ctrlE, validE) and both counters go to 0 without waiting for a clock. StallF and StallD are therefore 0. First capture occurs on the first rising edge after reset is released.

## Test plan
- Reset mid-stream with registers loaded: drive reset=0 → all outputs, both counters and every register read are 0 immediately.
- Write x5=0xDEADBEEF while instrD reads rs1=5 → ReadOut1E = 0xDEADBEEF next edge (BYPASS=1), and the prior value with BYPASS=0. Write to x0 → x0 still reads 0.
- lw x7 in E (MemRead=1), add x8,x7,x1 in D → StallD=1 for 1 cycle, bubble in E (validE=0, ctrlE=0), add enters E on the following edge, stall_cycles=1.
- Same load-use case with FlushE=1 → StallD=0, validE=0, flush_cycles=1, stall_cycles=0. Load with RdE=0 → no stall.
- NREGS=16: write to x20 is ignored; read of x20 returns 0.
- Force 2^CNT_W+3 stall cycles → stall_cycles holds at all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: register file with optional write-through bypass,
// ID/EX pipeline register with bubble insertion, load-use stall detection and event counters.
module id_ex_stage #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int CTRL_W      = 12,
    parameter int MEMREAD_BIT = 1,
    parameter int BYPASS      = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteAddressW,
    input  logic [XLEN-1:0]   writeDataW,
    input  logic              validD,
    input  logic [31:0]       instrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [XLEN-1:0]   immD,
    input  logic              FlushE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   ReadOut1E,
    output logic [XLEN-1:0]   ReadOut2E,
    output logic [XLEN-1:0]   ImmE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              validE,
    output logic              StallF,
    output logic              StallD,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_cycles
);

    localparam int AW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] rf [NREGS];
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wr_ok;
    logic            load_use;
    logic            bubble;
    logic            unused_instr;

    assign rs1 = instrD[19:15];
    assign rs2 = instrD[24:20];
    assign rd  = instrD[11:7];
    assign unused_instr = ^{instrD[31:25], instrD[14:12], instrD[6:0]};

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < 6'(NREGS));
    endfunction

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != 5'd0 && in_range(a)) begin
            if (BYPASS != 0 && RegWriteW && WriteAddressW == a)
                v = writeDataW;
            else
                v = rf[a[AW-1:0]];
        end
        return v;
    endfunction

    assign wr_ok = RegWriteW && (WriteAddressW != 5'd0) && in_range(WriteAddressW);

    always_comb begin
        rd1 = rf_read(rs1);
        rd2 = rf_read(rs2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wr_ok) begin
            rf[WriteAddressW[AW-1:0]] <= writeDataW;
        end
    end

    // Both source fields are compared whatever the format; a false stall only costs a cycle.
    assign load_use = validE && ctrlE[MEMREAD_BIT] && (RdE != 5'd0) && validD &&
                      ((RdE == rs1) || (RdE == rs2));
    assign StallD   = load_use && !FlushE;
    assign StallF   = StallD;
    assign bubble   = FlushE || load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCE       <= '0;
            ReadOut1E <= '0;
            ReadOut2E <= '0;
            ImmE      <= '0;
            ctrlE     <= '0;
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            validE    <= 1'b0;
        end else begin
            PCE       <= PCD;
            ReadOut1E <= rd1;
            ReadOut2E <= rd2;
            ImmE      <= immD;
            Rs1E      <= rs1;
            Rs2E      <= rs2;
            RdE       <= rd;
            validE    <= validD && !bubble;
            ctrlE     <= (validD && !bubble) ? ctrlD : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (StallD && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
            if (FlushE && flush_cycles != CNT_MAX) flush_cycles <= flush_cycles + 1'b1;
        end
    end

endmodule
